// File: rtl/banco_reg_ctrl.sv
// banco_reg_ctrl: valid/ready command sequencer for the banco_reg bank with write read-back verify.
module banco_reg_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rsp_mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] sel,
  output logic              RegWrite,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] selA,
  output logic [ADDR_W-1:0] selB,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2
);
  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;
  state_t state_q, state_d;
  logic ph_q, ph_d, wr_q, wr_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, sel_q, sel_d;
  logic [DATA_W-1:0] wd_q, wd_d, data_q, data_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, reg_write_q, reg_write_d;
  logic rsp_write_q, rsp_write_d, rsp_mismatch_q, rsp_mismatch_d;
  logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d, rsp_data_b_q, rsp_data_b_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic acc, cap, mis;
  // RD spans two cycles: a settle cycle after selA/selB are stable, then the capture edge
  always_comb begin
    acc = req_valid && req_ready_q;
    cap = (state_q == RD) && ph_q;
    mis = wr_q && (ReadData1 != wd_q);
    state_d = (state_q == IDLE) ? (acc ? (req_write ? WR : RD) : IDLE)
            : (state_q == WR)   ? RD
            : (state_q == RD)   ? (ph_q ? RSP : RD)
            : (rsp_ready ? IDLE : RSP);
    ph_d = (state_q == RD) && !ph_q;
    wr_d = acc ? req_write : wr_q;
    a_d = acc ? req_addr_a : a_q;
    b_d = acc ? req_addr_b : b_q;
    wd_d = acc ? req_wdata : wd_q;
    sel_d = (acc && req_write) ? req_addr_a : sel_q;
    data_d = (acc && req_write) ? req_wdata : data_q;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RSP;
    reg_write_d = state_d == WR;
    rsp_write_d = cap ? wr_q : rsp_write_q;
    rsp_data_a_d = cap ? ReadData1 : rsp_data_a_q;
    rsp_data_b_d = cap ? ReadData2 : rsp_data_b_q;
    rsp_mismatch_d = cap ? mis : rsp_mismatch_q;
    err_count_d = (cap && mis && !(&err_count_q)) ? err_count_q + ERR_W'(1) : err_count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= 1'b0;
      wr_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      wd_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
      rsp_mismatch_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      wr_q <= wr_d;
      a_q <= a_d;
      b_q <= b_d;
      wd_q <= wd_d;
      sel_q <= sel_d;
      data_q <= data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      reg_write_q <= reg_write_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      err_count_q <= err_count_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data_a = rsp_data_a_q;
  assign rsp_data_b = rsp_data_b_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign err_count = err_count_q;
  assign sel = sel_q;
  assign RegWrite = reg_write_q;
  assign data = data_q;
  assign selA = a_q;
  assign selB = b_q;
endmodule

// File: tb/tb_banco_reg_ctrl.sv
// tb_banco_reg_ctrl: random and directed stimulus against a cycle-timed scoreboard of banco_reg_ctrl.
module tb_banco_reg_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = 2;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [AW-1:0] req_addr_a = 0, req_addr_b = 0;
  logic [DW-1:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_write, rsp_mismatch, RegWrite;
  logic [DW-1:0] rsp_data_a, rsp_data_b, data, ReadData1, ReadData2;
  logic [EW-1:0] err_count;
  logic [AW-1:0] sel, selA, selB;
  int total = 0, bad = 0;

  banco_reg_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_mismatch(rsp_mismatch),
    .err_count(err_count), .sel(sel), .RegWrite(RegWrite), .data(data),
    .selA(selA), .selB(selB), .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  // register bank environment; corrupt flips port A to provoke read-back mismatches
  logic [DW-1:0] bank [32];
  bit corrupt = 0;
  always @(posedge clk) if (RegWrite) bank[sel] <= data;
  assign ReadData1 = corrupt ? ~bank[selA] : bank[selA];
  assign ReadData2 = bank[selB];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: one command in flight, timed from its acceptance edge
  logic [DW-1:0] mem [32];
  bit busy = 0, rdy_ok = 0, mw = 0, emis = 0;
  int cyc = 0, t = 0, due = 0, ndone = 0, err = 0;
  logic [AW-1:0] ma = 0, mb = 0;
  logic [DW-1:0] mwd = 0, ea = 0, eb = 0, m_rd1;
  logic m_mis;
  assign m_rd1 = corrupt ? ~mem[ma] : mem[ma];
  assign m_mis = mw && (m_rd1 != mwd);

  always @(posedge clk) begin
    if (rst) begin
      busy <= 0;
      rdy_ok <= 0;
      err <= 0;
      cyc <= 0;
    end else begin
      if (busy && mw && cyc == t) mem[ma] <= mwd;
      if (busy && cyc == due - 1) begin
        ea <= m_rd1;
        eb <= mem[mb];
        emis <= m_mis;
        if (m_mis && err < (1 << EW) - 1) err <= err + 1;
      end
      if (busy && cyc >= due && rsp_ready) begin
        busy <= 0;
        ndone <= ndone + 1;
      end else if (rdy_ok && !busy && req_valid) begin
        busy <= 1;
        mw <= req_write;
        ma <= req_addr_a;
        mb <= req_addr_b;
        mwd <= req_wdata;
        t <= cyc + 1;
        due <= cyc + 1 + (req_write ? 3 : 2);
      end
      rdy_ok <= 1;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("req_ready", req_ready, rdy_ok && !busy);
    chk("rsp_valid", rsp_valid, busy && cyc >= due);
    chk("RegWrite", RegWrite, busy && mw && cyc == t);
    chk("err_count", err_count, err);
    if (busy && mw && cyc == t) begin
      chk("sel", sel, ma);
      chk("data", data, mwd);
    end
    if (busy) begin
      chk("selA", selA, ma);
      chk("selB", selB, mb);
    end
    if (busy && cyc >= due) begin
      chk("rsp_write", rsp_write, mw);
      chk("rsp_data_a", rsp_data_a, ea);
      chk("rsp_data_b", rsp_data_b, eb);
      chk("rsp_mismatch", rsp_mismatch, emis);
    end
  end

  task automatic op(input bit w, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [DW-1:0] wd,
                    input int hold, output logic [DW-1:0] oa, output logic [DW-1:0] ob,
                    output bit om, output bit ow, output int lat);
    int n = 0;
    @(negedge clk);
    req_valid = 1;
    req_write = w;
    req_addr_a = a;
    req_addr_b = b;
    req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    req_write = 1'($urandom);
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_timeout", rsp_valid, 1);
    repeat (hold) @(negedge clk);
    oa = rsp_data_a;
    ob = rsp_data_b;
    om = rsp_mismatch;
    ow = rsp_write;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    logic [DW-1:0] oa, ob;
    bit om, ow;
    int lat, base, ncyc;
    for (int i = 0; i < 32; i++) begin
      bank[i] = $urandom;
      mem[i] = bank[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_sel", sel, 0);
    chk("rst_selA", selA, 0);
    chk("rst_selB", selB, 0);
    chk("rst_rsp_data_a", rsp_data_a, 0);
    chk("rst_err", err_count, 0);
    #2 rst = 0;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);
    chk("rel_valid", rsp_valid, 0);
    req_valid = 1;
    req_write = 1;
    req_addr_a = 5'd3;
    req_wdata = 32'hA5A5_0003;
    @(negedge clk);
    req_valid = 0;
    chk("mid_wr_pulse", RegWrite, 1);
    chk("mid_wr_sel", sel, 3);
    #2 rst = 1;
    #1;
    chk("async_regwrite", RegWrite, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_sel", sel, 0);
    chk("async_data", data, 0);
    chk("async_selA", selA, 0);
    chk("async_err", err_count, 0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rel2_ready", req_ready, 1);
    chk("rel2_valid", rsp_valid, 0);
    op(1, 5'b10010, 5'd0, 32'hFFFF_FF99, 0, oa, ob, om, ow, lat);
    chk("wr_data_a", oa, 32'hFFFF_FF99);
    chk("wr_write", ow, 1);
    chk("wr_mis", om, 0);
    chk("wr_lat", lat, 3);
    op(0, 5'd18, 5'b10110, 0, 0, oa, ob, om, ow, lat);
    chk("rd_data_a", oa, 32'hFFFF_FF99);
    chk("rd_write", ow, 0);
    chk("rd_lat", lat, 2);
    op(1, 5'd26, 5'd0, 32'h1234_5678, 0, oa, ob, om, ow, lat);
    op(1, 5'd22, 5'd0, 32'hCAFE_0001, 0, oa, ob, om, ow, lat);
    op(0, 5'd26, 5'd22, 0, 10, oa, ob, om, ow, lat);
    chk("dual_a", oa, 32'h1234_5678);
    chk("dual_b", ob, 32'hCAFE_0001);
    chk("dual_write", ow, 0);
    chk("dual_mis", om, 0);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 1);
    corrupt = 1;
    for (int i = 0; i < 5; i++) begin
      op(1, AW'(i + 1), 5'd0, $urandom, 0, oa, ob, om, ow, lat);
      chk("mis_flag", om, 1);
      if (i == 0) chk("mis_err1", err_count, 1);
    end
    chk("mis_err_sat", err_count, 3);
    corrupt = 0;
    base = ndone;
    ncyc = 0;
    while (ndone - base < 1000 && ncyc < 30000) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr_a = AW'($urandom);
      req_addr_b = AW'($urandom);
      req_wdata = $urandom;
      rsp_ready = 1'($urandom);
      ncyc++;
    end
    chk("rand_count", ndone - base >= 1000, 1);
    @(negedge clk);
    req_valid = 0;
    rsp_ready = 1;
    repeat (8) @(negedge clk);
    chk("drain_ready", req_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
